// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 divider.
package div_pkg;

  localparam int DIV_W      = 32;
  localparam int DIV_STEPS  = 32;
  localparam int PR_W       = 2 * DIV_W + 1;
  localparam int CNT_W      = $clog2(DIV_STEPS);

  // {remainder, quotient} word layout, HI/LO order for the HILO write
  localparam int RES_HI_MSB = 63;
  localparam int RES_HI_LSB = 32;
  localparam int RES_LO_MSB = 31;
  localparam int RES_LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] v);
    return (~v) + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift partial remainder, trial-subtract divisor.
module div_step
  import div_pkg::*;
(
  input  logic [PR_W-1:0]  pr_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [PR_W-1:0]  pr_o,
  output logic             q_o
);

  logic [PR_W-1:0]  sh;
  logic [DIV_W+1:0] diff;

  always_comb begin
    sh   = pr_i << 1;
    // Extra top bit acts as the borrow: clear means the difference is non-negative
    diff = {1'b0, sh[PR_W-1:DIV_W]} - {2'b00, divisor_i};
    q_o  = ~diff[DIV_W+1];
    if (q_o) pr_o = {diff[DIV_W:0], sh[DIV_W-1:1], 1'b1};
    else     pr_o = sh;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider returning {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: zero divisor short-cuts through BYZERO.
module div_unit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_div,
  input  logic             signed_div,
  input  logic [DIV_W-1:0] opdata1,
  input  logic [DIV_W-1:0] opdata2,
  input  logic             annul,
  output logic             div_ready,
  output logic [63:0]      result
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PR_W-1:0]  pr_q, pr_d;
  logic [DIV_W-1:0] dvsr_q, dvsr_d;
  logic             sgn1_q, sgn1_d;
  logic             sgn2_q, sgn2_d;
  logic             div_ready_q, div_ready_d;
  logic [63:0]      result_q, result_d;

  logic [PR_W-1:0]  step_pr;
  logic             step_q;
  logic [DIV_W-1:0] quo_fix, rem_fix;

  div_step u_step (
    .pr_i      (pr_q),
    .divisor_i (dvsr_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_comb begin
    quo_fix = step_pr[RES_LO_MSB:RES_LO_LSB];
    rem_fix = step_pr[RES_HI_MSB:RES_HI_LSB];
    if (sgn1_q ^ sgn2_q) quo_fix = neg_w(quo_fix);
    if (sgn1_q)          rem_fix = neg_w(rem_fix);
  end

`ifdef DIV_ZERO_FAST_EN
  logic [DIV_W-1:0] zero_hi, zero_lo;
  always_comb begin
    // pr_q holds |dividend| here; restore the original operand
    zero_hi = sgn1_q ? neg_w(pr_q[DIV_W-1:0]) : pr_q[DIV_W-1:0];
    zero_lo = sgn1_q ? 32'h0000_0001 : 32'hFFFF_FFFF;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    dvsr_d      = dvsr_q;
    sgn1_d      = sgn1_q;
    sgn2_d      = sgn2_q;
    div_ready_d = 1'b0;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (start_div && !annul) begin
          sgn1_d  = signed_div & opdata1[DIV_W-1];
          sgn2_d  = signed_div & opdata2[DIV_W-1];
          pr_d    = {{(DIV_W+1){1'b0}}, sgn1_d ? neg_w(opdata1) : opdata1};
          dvsr_d  = sgn2_d ? neg_w(opdata2) : opdata2;
          cnt_d   = '0;
          state_d = ON;
`ifdef DIV_ZERO_FAST_EN
          if (opdata2 == '0) state_d = BYZERO;
`endif
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          pr_d  = step_pr;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
            pr_d    = {1'b0, rem_fix, quo_fix};
            state_d = DONE;
          end
        end
      end
`ifdef DIV_ZERO_FAST_EN
      BYZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          pr_d    = {1'b0, zero_hi, zero_lo};
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        result_d    = pr_q[63:0];
        div_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      dvsr_q      <= '0;
      sgn1_q      <= 1'b0;
      sgn2_q      <= 1'b0;
      div_ready_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      dvsr_q      <= dvsr_d;
      sgn1_q      <= sgn1_d;
      sgn2_q      <= sgn2_d;
      div_ready_q <= div_ready_d;
      result_q    <= result_d;
    end
  end

  assign div_ready = div_ready_q;
  assign result    = result_q;

  logic unused_step_q;
  assign unused_step_q = step_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_div;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        div_ready;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_div  (start_div),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .div_ready  (div_ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, (sd && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'h0) return 2;
`endif
    return 33;
  endfunction

  // Wait up to a bounded number of edges for div_ready; returns edge count or 0
  task automatic wait_ready(input int limit, output int lat);
    lat = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (div_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [63:0] exp;
    exp = ref_div(sd, a, b);
    @(negedge clk);
    start_div = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b;
    @(posedge clk); #1;
    start_div = 1'b0;
    signed_div = 1'($urandom); opdata1 = $urandom; opdata2 = $urandom;
    wait_ready(60, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'h0, div_ready}, 64'h0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int          lat;
    logic [63:0] prev;
    logic [31:0] a2, b2, ra, rb;
    logic        rs;
    bit          seen;

    resetn = 1'b0; start_div = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0; annul = 1'b0;
    #12;
    chk("rst_ready", {63'h0, div_ready}, 64'h0);
    chk("rst_result", result, 64'h0);
    @(negedge clk); resetn = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    chk("divu_100_7_val", result, {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_val", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_val", result, {32'h0, 32'h8000_0000});
    run_div("div_z", 1'b1, 32'hFFFF_FFF0, 32'h0);
    chk("div_z_val", result, {32'hFFFF_FFF0, 32'h0000_0001});
    run_div("divu_z", 1'b0, 32'd5, 32'h0);
    chk("divu_z_val", result, {32'd5, 32'hFFFF_FFFF});

    // Annul during iteration 10
    run_div("pre_annul", 1'b0, 32'd100, 32'd7);
    prev = result;
    @(negedge clk);
    start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd9;
    @(posedge clk); #1; start_div = 1'b0;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (div_ready) seen = 1'b1;
    end
    chk("annul_no_ready", {63'h0, seen}, 64'h0);
    chk("annul_result", result, prev);
    run_div("post_annul", 1'b0, 32'd9, 32'd3);
    chk("post_annul_val", result, {32'd0, 32'd3});

    // Asynchronous reset mid-divide
    @(negedge clk);
    start_div = 1'b1; signed_div = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
    @(posedge clk); #1; start_div = 1'b0;
    repeat (15) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_ready", {63'h0, div_ready}, 64'h0);
    chk("arst_result", result, 64'h0);
    @(negedge clk); resetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (div_ready) seen = 1'b1;
    end
    chk("arst_no_ready", {63'h0, seen}, 64'h0);

    // start_div held through DONE: recapture only in the following IDLE
    a2 = $urandom; b2 = $urandom | 32'h1;
    @(negedge clk);
    start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'hDEAD_BEEF; opdata2 = 32'd1234;
    @(posedge clk); #1;
    signed_div = 1'b1; opdata1 = a2; opdata2 = b2;
    wait_ready(60, lat);
    chk("hold_lat1", 64'(lat), 64'd33);
    chk("hold_res1", result, ref_div(1'b0, 32'hDEAD_BEEF, 32'd1234));
    @(posedge clk); #1; start_div = 1'b0;
    wait_ready(60, lat);
    chk("hold_lat2", 64'(lat), 64'd33);
    chk("hold_res2", result, ref_div(1'b1, a2, b2));
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = $urandom_range(0, 50);
      run_div($sformatf("rand%0d", i), rs, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit radix-2 divider: the responder side of the ALU divide handshake (`start_div`/`signed_div` in, `div_ready` out). It sits beside the ALU in the execute stage. It captures the operands when a divide is requested, iterates one quotient bit per cycle, and returns a 64-bit `{remainder, quotient}` word in HI/LO order, ready for the HILO register write.

## Interface
- Parameters: none; operand width is fixed at 32 through the package constant `DIV_W`.
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start_div`  in  1  divide request; held high by the ALU until it sees `div_ready`
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_div`
- `opdata1`  in  32  dividend; sampled with `start_div`
- `opdata2`  in  32  divisor; sampled with `start_div`
- `annul`  in  1  flush (exception/branch kill); aborts an in-flight divide
- `div_ready`  out  1  registered one-cycle pulse; `result` valid
- `result`  out  64  `{remainder[31:0], quotient[31:0]}` (HI, LO)

## Operation
- FSM states:
  - `IDLE`: waiting for a request.
  - `BYZERO`: zero divisor detected; only reached when `DIV_ZERO_FAST_EN` is defined.
  - `ON`: iterating.
  - `DONE`: `div_ready` = 1.
- Transitions:
  - `IDLE` with `start_div`=1 and `annul`=0: capture `signed_div`, |`opdata1`|, |`opdata2`|, and both sign bits. Clear the counter. Go to `ON`, or to `BYZERO` when the divisor is 0 and the macro is defined.
  - `ON`: perform one restoring step per cycle. The 65-bit partial remainder shifts left, then the divisor is subtracted; a non-negative difference sets quotient bit 1 and is kept. After step 32 (counter = 31), apply the sign fixup and go to `DONE`.
  - `BYZERO`: load the zero-divide result and go to `DONE`.
  - `DONE`: go to `IDLE` unconditionally. A `start_div` seen in `DONE` is ignored; it is accepted in the following `IDLE` cycle.
  - `annul`=1 in `ON` or `BYZERO`: go to `IDLE` next edge. `div_ready` stays 0 and `result` is unchanged.
- Sign fixup (signed only): quotient is negated when the two operand signs differ. Remainder takes the sign of the dividend.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0. There is no trap.
- Zero divisor result (identical with or without the macro): HI = `opdata1` unchanged. LO = 0x00000001 if signed and `opdata1[31]`=1, otherwise 0xFFFFFFFF.
- Operand changes after capture are ignored.

## Timing
- Reset values: state `IDLE`, `div_ready` 0, `result` 64'h0, counter 0.
- Latency: `start_div` is sampled at edge E0, and `div_ready` is high during the cycle after edge E33. That is 33 cycles for normal operands, and 2 cycles for a zero divisor with `DIV_ZERO_FAST_EN`.
- `div_ready` is high for exactly one cycle. `result` holds its value until the next completed divide.
- `resetn` low at any point, including mid-`ON`: all state returns to reset values immediately (asynchronous).
- Back-to-back divides: the next request can be captured 2 cycles after a `DONE` cycle begins (`DONE`→`IDLE`→capture).

## Configuration
- `DIV_ZERO_FAST_EN` defined: a zero divisor takes the `BYZERO` path, giving a latency of 2.
- `DIV_ZERO_FAST_EN` undefined: the `BYZERO` state is not built. A zero divisor runs the full 32 steps, giving a latency of 33, and produces the same result value.

## Structure
- Package `div_pkg` holds:
  - `DIV_W` = 32.
  - `DIV_STEPS` = 32.
  - The state enum `div_state_t` (`IDLE`, `BYZERO`, `ON`, `DONE`).
  - The result layout constants (HI = [63:32], LO = [31:0]).
- Sub-module `div_step` is one combinational restoring iteration: 65-bit partial remainder plus divisor in, next partial remainder plus quotient bit out. It is instantiated once in `div_unit`.

## Test plan
- Unsigned: 100 / 7 (DIVU) → `result` = {32'd2, 32'd14}; `div_ready` is high exactly 33 cycles after the start edge, for 1 cycle.
- Signed: -7 / 2 (DIV) → HI 0xFFFFFFFF, LO 0xFFFFFFFD. Signed: 0x80000000 / 0xFFFFFFFF → HI 0, LO 0x80000000.
- Zero divisor: DIV with 0xFFFFFFF0 / 0 → HI 0xFFFFFFF0, LO 0x00000001. DIVU 5 / 0 → HI 5, LO 0xFFFFFFFF. Check latency 2 with the macro and 33 without.
- `annul` asserted on iteration 10 → no `div_ready` pulse, `result` keeps its previous value. A new 9/3 request then yields {0, 3}.
- `resetn` pulsed low mid-divide → `div_ready` 0 and `result` 0 asynchronously. With `start_div` held through `DONE`, a second divide starts only after `IDLE`; operand changes during `ON` do not affect the result.
